// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter. The in-order pipeline writeback (A) always
// wins the slot. Long-latency results (B) go into a small FIFO that drains
// into idle slots. A starvation counter raises an advisory stall toward the
// pipeline. Pending-write hit flags report B writes that are queued or in flight.
module regfile_wb_arbiter #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4,
  localparam int ADDR        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [ADDR-1:0]  a_reg,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [ADDR-1:0]  b_reg,
  input  logic [WIDTH-1:0] b_data,
  output logic             stall_a,
  input  logic [ADDR-1:0]  rreg1,
  input  logic [ADDR-1:0]  rreg2,
  output logic             pend_hit1,
  output logic             pend_hit2,
  output logic             wen,
  output logic [ADDR-1:0]  wreg,
  output logic [WIDTH-1:0] wdata
);

  localparam int FIDX = $clog2(FIFO_DEPTH);
  localparam int PW   = FIDX + 1;
  localparam int CW   = $clog2(STARVE_LIMIT + 1);

  logic [ADDR-1:0]  fifo_reg  [FIFO_DEPTH];
  logic [WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    count;
  logic             full;
  logic             empty;
  logic             a_win;
  logic             pop;
  logic             push;
  logic [CW-1:0]    starve_cnt;
  logic             stall_next;
  logic             wen_b;
  logic [FIFO_DEPTH-1:0] ent_valid;
  logic [FIFO_DEPTH-1:0] hit1;
  logic [FIFO_DEPTH-1:0] hit2;

  // Occupancy comes only from the registered pointers, so b_ready never
  // depends on a pop that happens in the same cycle.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[FIDX] != rd_ptr[FIDX]) &&
                   (wr_ptr[FIDX-1:0] == rd_ptr[FIDX-1:0]);
  assign b_ready = !full;

  // A write to register 0 is a no-op, so it does not claim the slot.
  assign a_win = a_valid && (a_reg != '0);
  assign pop   = !a_win && !empty;
  assign push  = b_valid && !full && (b_reg != '0);

  // An entry is live when its distance from the read pointer is below the occupancy.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
    logic [FIDX-1:0] offset;
    assign offset        = FIDX'(gi) - rd_ptr[FIDX-1:0];
    assign ent_valid[gi] = {1'b0, offset} < count;
    assign hit1[gi]      = ent_valid[gi] && (fifo_reg[gi] == rreg1);
    assign hit2[gi]      = ent_valid[gi] && (fifo_reg[gi] == rreg2);
  end

  // A B write on the port lands at the coming edge, so it still counts as pending.
  assign pend_hit1 = (rreg1 != '0) && ((|hit1) || (wen_b && (wreg == rreg1)));
  assign pend_hit2 = (rreg2 != '0) && ((|hit2) || (wen_b && (wreg == rreg2)));

  // FIFO storage. Stale slots are masked by ent_valid, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg[wr_ptr[FIDX-1:0]]  <= b_reg;
      fifo_data[wr_ptr[FIDX-1:0]] <= b_data;
    end
  end

  // FIFO pointers. Reset empties the queue and discards pending B writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // The stall is raised when the head has waited long enough and is still not leaving.
  assign stall_next = !empty && !pop && (starve_cnt >= CW'(STARVE_LIMIT - 1));

  // Count the cycles the B head has waited. The count saturates so it cannot wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      stall_a    <= 1'b0;
    end else begin
      stall_a <= stall_next;
      if (empty || pop) begin
        starve_cnt <= '0;
      end else if (starve_cnt != CW'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  // Registered write port. wreg and wdata keep their last value on idle slots.
  always_ff @(posedge clk) begin
    if (reset) begin
      wen   <= 1'b0;
      wen_b <= 1'b0;
      wreg  <= '0;
      wdata <= '0;
    end else if (a_win) begin
      wen   <= 1'b1;
      wen_b <= 1'b0;
      wreg  <= a_reg;
      wdata <= a_data;
    end else if (pop) begin
      wen   <= 1'b1;
      wen_b <= 1'b1;
      wreg  <= fifo_reg[rd_ptr[FIDX-1:0]];
      wdata <= fifo_data[rd_ptr[FIDX-1:0]];
    end else begin
      wen   <= 1'b0;
      wen_b <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter. A queue-based model predicts the
// outputs, one process compares them every cycle, and literal checks pin the model.
module tb_regfile_wb_arbiter;

  localparam int WIDTH = 32;
  localparam int ADDR  = 5;
  localparam int FD    = 2;
  localparam int SL    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             a_valid;
  logic [ADDR-1:0]  a_reg;
  logic [WIDTH-1:0] a_data;
  logic             b_valid;
  logic             b_ready;
  logic [ADDR-1:0]  b_reg;
  logic [WIDTH-1:0] b_data;
  logic             stall_a;
  logic [ADDR-1:0]  rreg1;
  logic [ADDR-1:0]  rreg2;
  logic             pend_hit1;
  logic             pend_hit2;
  logic             wen;
  logic [ADDR-1:0]  wreg;
  logic [WIDTH-1:0] wdata;

  int errors = 0;
  int checks = 0;
  bit check_en = 0;

  regfile_wb_arbiter #(.WIDTH(WIDTH), .DEPTH(32), .FIFO_DEPTH(FD), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .stall_a(stall_a), .rreg1(rreg1), .rreg2(rreg2),
    .pend_hit1(pend_hit1), .pend_hit2(pend_hit2),
    .wen(wen), .wreg(wreg), .wdata(wdata)
  );

  always #5 clk = ~clk;

  // Model state: the queued B writes plus the expected registered outputs.
  typedef struct {logic [ADDR-1:0] r; logic [WIDTH-1:0] d;} ent_t;
  ent_t             q[$];
  logic             exp_wen, exp_from_b, exp_stall;
  logic [ADDR-1:0]  exp_wreg;
  logic [WIDTH-1:0] exp_wdata;
  int               head_wait;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit model_pend(input logic [ADDR-1:0] r);
    if (r == 0) return 0;
    foreach (q[i]) if (q[i].r == r) return 1;
    return exp_wen && exp_from_b && (exp_wreg == r);
  endfunction

  // Model: A wins when it targets a nonzero register; otherwise the oldest B entry leaves.
  always @(posedge clk) begin
    bit a_win, do_pop, was_full, do_push;
    ent_t e;
    if (reset) begin
      q.delete();
      exp_wen    <= 0;
      exp_from_b <= 0;
      exp_wreg   <= 0;
      exp_wdata  <= 0;
      exp_stall  <= 0;
      head_wait  <= 0;
    end else begin
      a_win    = a_valid && (a_reg != 0);
      do_pop   = !a_win && (q.size() > 0);
      was_full = (q.size() == FD);
      do_push  = b_valid && !was_full && (b_reg != 0);
      exp_stall <= (q.size() > 0) && !do_pop && (head_wait >= SL - 1);
      head_wait <= ((q.size() == 0) || do_pop) ? 0 : head_wait + 1;
      if (a_win) begin
        exp_wen <= 1; exp_from_b <= 0; exp_wreg <= a_reg; exp_wdata <= a_data;
      end else if (do_pop) begin
        e = q.pop_front();
        exp_wen <= 1; exp_from_b <= 1; exp_wreg <= e.r; exp_wdata <= e.d;
      end else begin
        exp_wen <= 0; exp_from_b <= 0;
      end
      if (do_push) q.push_back('{r: b_reg, d: b_data});
    end
  end

  // Compare process: every output is checked against the model on each falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("m_wen", 32'(wen), 32'(exp_wen));
      if (exp_wen) begin
        chk("m_wreg", 32'(wreg), 32'(exp_wreg));
        chk("m_wdata", wdata, exp_wdata);
      end
      chk("m_b_ready", 32'(b_ready), 32'(q.size() < FD));
      chk("m_stall_a", 32'(stall_a), 32'(exp_stall));
      chk("m_pend1", 32'(pend_hit1), 32'(model_pend(rreg1)));
      chk("m_pend2", 32'(pend_hit2), 32'(model_pend(rreg2)));
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_a(input logic v, input logic [ADDR-1:0] r, input logic [WIDTH-1:0] d);
    a_valid = v; a_reg = r; a_data = d;
  endtask

  task automatic set_b(input logic v, input logic [ADDR-1:0] r, input logic [WIDTH-1:0] d);
    b_valid = v; b_reg = r; b_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1;
    set_a(0, 0, 0);
    set_b(0, 0, 0);
    rreg1 = 5; rreg2 = 7;
    cyc();
    cyc();
    check_en = 1;
    chk("rst_wen", 32'(wen), 0);
    chk("rst_wdata", wdata, 0);
    reset = 0;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_wen", 32'(wen), 0);
      chk("idle_b_ready", 32'(b_ready), 1);
      chk("idle_stall", 32'(stall_a), 0);
      chk("idle_pend1", 32'(pend_hit1), 0);
      chk("idle_pend2", 32'(pend_hit2), 0);
    end

    // A only, then an A write to r0, which must be dropped.
    set_a(1, 5, 32'hDEAD);
    cyc();
    $display("txn A r5 -> wen=%0b wreg=%0d wdata=%0h", wen, wreg, wdata);
    chk("a_wen", 32'(wen), 1);
    chk("a_wreg", 32'(wreg), 5);
    chk("a_wdata", wdata, 32'hDEAD);
    set_a(1, 0, 32'h1234);
    cyc();
    $display("txn A r0 -> wen=%0b", wen);
    chk("a0_wen", 32'(wen), 0);
    chk("a0_hold", wdata, 32'hDEAD);
    set_a(0, 0, 0);

    // A B write to r0 completes the handshake but pushes nothing.
    set_b(1, 0, 32'h55);
    cyc();
    chk("b0_ready", 32'(b_ready), 1);
    set_b(0, 0, 0);
    cyc();
    $display("txn B r0 -> wen=%0b", wen);
    chk("b0_wen", 32'(wen), 0);

    // B fill while A occupies every slot.
    rreg1 = 8; rreg2 = 9;
    set_a(1, 1, 32'h101); set_b(1, 7, 32'h70);
    cyc();
    chk("fill1_ready", 32'(b_ready), 1);
    chk("fill1_wreg", 32'(wreg), 1);
    set_a(1, 1, 32'h102); set_b(1, 8, 32'h80);
    cyc();
    $display("txn B fill r7,r8 -> b_ready=%0b pend1=%0b", b_ready, pend_hit1);
    chk("fill2_ready", 32'(b_ready), 0);
    chk("fill2_pend1", 32'(pend_hit1), 1);
    chk("fill2_pend2", 32'(pend_hit2), 0);
    set_a(1, 1, 32'h103); set_b(1, 9, 32'h90);
    cyc();
    chk("fill3_stall", 32'(stall_a), 0);
    set_a(1, 1, 32'h104);
    cyc();
    chk("fill4_stall", 32'(stall_a), 0);
    set_a(1, 1, 32'h105);
    cyc();
    $display("txn starve -> stall_a=%0b", stall_a);
    chk("fill5_stall", 32'(stall_a), 1);

    // Release A: the queued B writes drain in push order.
    set_a(0, 0, 0);
    cyc();
    $display("txn drain -> wen=%0b wreg=%0d wdata=%0h", wen, wreg, wdata);
    chk("drain7_wreg", 32'(wreg), 7);
    chk("drain7_wdata", wdata, 32'h70);
    chk("drain7_stall", 32'(stall_a), 0);
    chk("drain7_pend2", 32'(pend_hit2), 0);
    cyc();
    set_b(0, 0, 0);
    $display("txn drain -> wen=%0b wreg=%0d wdata=%0h", wen, wreg, wdata);
    chk("drain8_wreg", 32'(wreg), 8);
    chk("drain8_wdata", wdata, 32'h80);
    chk("drain8_pend2", 32'(pend_hit2), 1);
    cyc();
    $display("txn drain -> wen=%0b wreg=%0d wdata=%0h", wen, wreg, wdata);
    chk("drain9_wreg", 32'(wreg), 9);
    chk("drain9_wdata", wdata, 32'h90);
    chk("drain9_pend2", 32'(pend_hit2), 1);
    cyc();
    chk("drained_wen", 32'(wen), 0);
    chk("drained_pend2", 32'(pend_hit2), 0);

    // Mixed: A beats a non-empty FIFO; the next idle slot pops B.
    rreg1 = 3; rreg2 = 0;
    set_a(1, 4, 32'h44); set_b(1, 3, 32'h33);
    cyc();
    chk("mix_wreg4", 32'(wreg), 4);
    set_a(1, 6, 32'h66); set_b(0, 0, 0);
    cyc();
    $display("txn mixed A r6 -> wreg=%0d pend1=%0b", wreg, pend_hit1);
    chk("mix_wreg6", 32'(wreg), 6);
    chk("mix_pend1", 32'(pend_hit1), 1);
    set_a(0, 0, 0);
    cyc();
    $display("txn mixed B pop -> wreg=%0d wdata=%0h", wreg, wdata);
    chk("mix_wreg3", 32'(wreg), 3);
    chk("mix_wdata3", wdata, 32'h33);
    chk("mix_pend1_fly", 32'(pend_hit1), 1);
    cyc();
    chk("mix_idle_wen", 32'(wen), 0);
    chk("mix_idle_pend1", 32'(pend_hit1), 0);

    // Reset with two queued B writes discards them.
    rreg1 = 10; rreg2 = 11;
    set_a(1, 2, 32'h22); set_b(1, 10, 32'hA0);
    cyc();
    set_a(1, 2, 32'h23); set_b(1, 11, 32'hB0);
    cyc();
    chk("q2_ready", 32'(b_ready), 0);
    chk("q2_pend1", 32'(pend_hit1), 1);
    reset = 1; set_b(0, 0, 0);
    cyc();
    chk("rst2_wen", 32'(wen), 0);
    reset = 0; set_a(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      $display("txn post-reset %0d -> wen=%0b b_ready=%0b", i, wen, b_ready);
      chk("rst2_idle_wen", 32'(wen), 0);
      chk("rst2_ready", 32'(b_ready), 1);
      chk("rst2_pend1", 32'(pend_hit1), 0);
      chk("rst2_pend2", 32'(pend_hit2), 0);
    end

    check_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
